fwd_scoreboard: RTL



---
 rtl/fwd_scoreboard.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
//
// Forwarding and load-use stall controller for the pipelined CPU. It tracks
// the destination registers of in-flight instructions in a shift-register
// scoreboard (entry 1 = EX, 2 = MEM, 3 = WB, ...). The sources of the ID
// instruction are checked against that scoreboard to produce:
//   - a registered forward select per operand, valid during the EX cycle;
//   - a combinational stall for load-use hazards.
//
// Optional feature: define FWD_STATS_EN to add a saturating 16-bit stall
// cycle counter on port stall_count.
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   id_valid     in   valid instruction in ID
//   id_wr        in   ID instruction writes a register
//   id_rd        in   ID destination register
//   id_load      in   ID instruction is a load
//   src_addr     in   source addresses, operand i at [i*ADDR_W +: ADDR_W]
//   src_used     in   operand i is actually read
//   fwd_sel      out  registered per-operand select (0 = register file,
//                     k = forward from the entry that was at index k)
//   stall        out  combinational load-use stall
//   stall_count  out  stall cycle counter (FWD_STATS_EN only)
// -----------------------------------------------------------------------------
module fwd_scoreboard #(
  parameter  int ADDR_W     = 4,
  parameter  int DEPTH      = 3,
  parameter  int NSRC       = 2,
  parameter  int LOAD_READY = 2,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic                    id_wr,
  input  logic [ADDR_W-1:0]       id_rd,
  input  logic                    id_load,
  input  logic [NSRC*ADDR_W-1:0]  src_addr,
  input  logic [NSRC-1:0]         src_used,
  output logic [NSRC*SEL_W-1:0]   fwd_sel,
  output logic                    stall
`ifdef FWD_STATS_EN
  ,output logic [15:0]            stall_count
`endif
);

  // Scoreboard entries 1..DEPTH; index 1 is the youngest (currently in EX).
  logic              r_vld [1:DEPTH];
  logic [ADDR_W-1:0] r_rd  [1:DEPTH];
  logic              r_ld  [1:DEPTH];

  logic [NSRC*SEL_W-1:0] r_fwd_sel;
  logic [NSRC*SEL_W-1:0] w_sel;
  logic [NSRC-1:0]       w_hazard;
  logic                  w_push;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      logic [ADDR_W-1:0] w_addr;
      logic              w_active;
      logic [SEL_W-1:0]  w_m;
      logic              w_m_ld;

      assign w_addr   = src_addr[gi*ADDR_W +: ADDR_W];
      assign w_active = id_valid & src_used[gi] & (w_addr != '0);

      // Scan oldest to youngest so the lowest matching index (the youngest
      // writer) is the one left standing.
      always_comb begin
        w_m    = '0;
        w_m_ld = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
          if (r_vld[k] && (r_rd[k] == w_addr)) begin
            w_m    = SEL_W'(k);
            w_m_ld = r_ld[k];
          end
        end
      end

      // A young load that cannot forward yet blocks the operand outright;
      // an older ready writer to the same register must not be used instead.
      assign w_hazard[gi] = w_active && (w_m != '0) && w_m_ld &&
                            (int'(w_m) < LOAD_READY);
      assign w_sel[gi*SEL_W +: SEL_W] = (w_active && !w_hazard[gi]) ? w_m : '0;
    end
  endgenerate

  assign stall  = |w_hazard;
  assign w_push = id_valid & id_wr & (id_rd != '0) & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_vld[k] <= 1'b0;
        r_rd[k]  <= '0;
        r_ld[k]  <= 1'b0;
      end
      r_fwd_sel <= '0;
    end else begin
      // A stalled cycle pushes a bubble and the EX selects are cleared.
      r_vld[1] <= w_push;
      r_rd[1]  <= id_rd;
      r_ld[1]  <= id_load;
      for (int k = DEPTH; k >= 2; k--) begin
        r_vld[k] <= r_vld[k-1];
        r_rd[k]  <= r_rd[k-1];
        r_ld[k]  <= r_ld[k-1];
      end
      r_fwd_sel <= stall ? '0 : w_sel;
    end
  end

  assign fwd_sel = r_fwd_sel;

`ifdef FWD_STATS_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule
